fdsti_fdssi_seq_arb: RTL and testbench

//  Time-multiplexed arbiter sharing one FDSTI/FDSSI compare stage between
//  2**O_SAM_WIDTH requesters. Snapshots pending requests, scans them one per

---
 rtl/fdsti_fdssi_seq_arb_if.sv | 34 +++
 rtl/fdsti_fdssi_seq_arb.sv | 169 ++++++++++++++++
 tb/tb_fdsti_fdssi_seq_arb.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fdsti_fdssi_seq_arb_if.sv
// Request/result bundle for the sequential FDSTI/FDSSI arbiter.
// The master side belongs to the requesters and the consumer. The slave side is the arbiter.
interface fdsti_fdssi_seq_arb_if #(
  parameter int O_SAM_WIDTH   = 2,
  parameter int I_FDSTI_WIDTH = 28,
  parameter int I_FDSSI_WIDTH = 12
);
  localparam int N   = 1 << O_SAM_WIDTH;
  localparam int IDW = (O_SAM_WIDTH > 0) ? O_SAM_WIDTH : 1;

  logic                       cfg_en;
  logic [N-1:0]               req_valid;
  logic [N-1:0]               req_wt;
  logic [I_FDSTI_WIDTH*N-1:0] req_fdsti;
  logic [I_FDSSI_WIDTH*N-1:0] req_fdssi;
  logic [N-1:0]               req_grant;
  logic                       out_valid;
  logic                       out_ready;
  logic [IDW-1:0]             out_id;
  logic                       out_wt;
  logic [I_FDSTI_WIDTH-1:0]   out_fdsti;
  logic [I_FDSSI_WIDTH-1:0]   out_fdssi;
  logic                       busy;

  modport master (
    output cfg_en, req_valid, req_wt, req_fdsti, req_fdssi, out_ready,
    input  req_grant, out_valid, out_id, out_wt, out_fdsti, out_fdssi, busy
  );

  modport slave (
    input  cfg_en, req_valid, req_wt, req_fdsti, req_fdssi, out_ready,
    output req_grant, out_valid, out_id, out_wt, out_fdsti, out_fdssi, busy
  );
endinterface

// File: rtl/fdsti_fdssi_seq_arb.sv
// Time-multiplexed FDSTI/FDSSI arbiter. It snapshots the pending requests and scans one requester per cycle
// in round-robin order. It presents the winner on a valid/ready output, then pops the winner with a one-cycle grant.
module fdsti_fdssi_seq_arb #(
  parameter int O_SAM_WIDTH   = 2,
  parameter int I_FDSTI_WIDTH = 28,
  parameter int I_FDSSI_WIDTH = 12
) (
  input logic clk,
  input logic rst_n,
  fdsti_fdssi_seq_arb_if.slave bus
);
  localparam int N   = 1 << O_SAM_WIDTH;
  localparam int IDW = (O_SAM_WIDTH > 0) ? O_SAM_WIDTH : 1;
  localparam logic [IDW-1:0] ID_MASK = IDW'(N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_OUT} state_t;

  state_t                   state_reg, state_next;
  logic [N-1:0]             cand_reg, cand_next;
  logic [IDW-1:0]           cnt_reg, cnt_next;
  logic [IDW-1:0]           rr_ptr_reg, rr_ptr_next;
  logic                     have_best_reg, have_best_next;
  logic [IDW-1:0]           best_id_reg, best_id_next;
  logic                     best_wt_reg, best_wt_next;
  logic [I_FDSTI_WIDTH-1:0] best_fdsti_reg, best_fdsti_next;
  logic [I_FDSSI_WIDTH-1:0] best_fdssi_reg, best_fdssi_next;
  logic                     out_valid_reg, out_valid_next;
  logic [IDW-1:0]           out_id_reg, out_id_next;
  logic                     out_wt_reg, out_wt_next;
  logic [I_FDSTI_WIDTH-1:0] out_fdsti_reg, out_fdsti_next;
  logic [I_FDSSI_WIDTH-1:0] out_fdssi_reg, out_fdssi_next;
  logic [N-1:0]             grant_reg, grant_next;

  logic [I_FDSTI_WIDTH-1:0] fdsti_arr [N];
  logic [I_FDSSI_WIDTH-1:0] fdssi_arr [N];
  logic [IDW-1:0]           scan_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign fdsti_arr[gi] = bus.req_fdsti[gi*I_FDSTI_WIDTH +: I_FDSTI_WIDTH];
    assign fdssi_arr[gi] = bus.req_fdssi[gi*I_FDSSI_WIDTH +: I_FDSSI_WIDTH];
  end

  // The mask gives mod-N wrap. With N=1 it pins the index to 0.
  assign scan_idx = (rr_ptr_reg + cnt_reg) & ID_MASK;

  // Weight dominates, then smaller FDSTI, then smaller FDSSI. A full tie is not better.
  function automatic logic better(
    input logic                     wa,
    input logic [I_FDSTI_WIDTH-1:0] ta,
    input logic [I_FDSSI_WIDTH-1:0] sa,
    input logic                     wb,
    input logic [I_FDSTI_WIDTH-1:0] tb,
    input logic [I_FDSSI_WIDTH-1:0] sb
  );
    if (wa != wb) return wa;
    if (ta != tb) return ta < tb;
    return sa < sb;
  endfunction

  always_comb begin
    state_next      = state_reg;
    cand_next       = cand_reg;
    cnt_next        = cnt_reg;
    rr_ptr_next     = rr_ptr_reg;
    have_best_next  = have_best_reg;
    best_id_next    = best_id_reg;
    best_wt_next    = best_wt_reg;
    best_fdsti_next = best_fdsti_reg;
    best_fdssi_next = best_fdssi_reg;
    out_valid_next  = out_valid_reg;
    out_id_next     = out_id_reg;
    out_wt_next     = out_wt_reg;
    out_fdsti_next  = out_fdsti_reg;
    out_fdssi_next  = out_fdssi_reg;
    grant_next      = '0;
    case (state_reg)
      ST_IDLE: begin
        // Hold off while a grant is visible so a popped requester is not re-sampled.
        if (bus.cfg_en && (|bus.req_valid) && (grant_reg == '0)) begin
          cand_next      = bus.req_valid;
          cnt_next       = '0;
          have_best_next = 1'b0;
          state_next     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cand_reg[scan_idx] &&
            (!have_best_reg ||
             better(bus.req_wt[scan_idx], fdsti_arr[scan_idx], fdssi_arr[scan_idx],
                    best_wt_reg, best_fdsti_reg, best_fdssi_reg))) begin
          have_best_next  = 1'b1;
          best_id_next    = scan_idx;
          best_wt_next    = bus.req_wt[scan_idx];
          best_fdsti_next = fdsti_arr[scan_idx];
          best_fdssi_next = fdssi_arr[scan_idx];
        end
        if (cnt_reg == ID_MASK) state_next = ST_OUT;
        else                    cnt_next   = cnt_reg + IDW'(1);
      end
      ST_OUT: begin
        if (!out_valid_reg) begin
          out_valid_next = 1'b1;
          out_id_next    = best_id_reg;
          out_wt_next    = best_wt_reg;
          out_fdsti_next = best_fdsti_reg;
          out_fdssi_next = best_fdssi_reg;
        end else if (bus.out_ready) begin
          grant_next[out_id_reg] = 1'b1;
          rr_ptr_next    = (out_id_reg + IDW'(1)) & ID_MASK;
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cand_reg       <= '0;
      cnt_reg        <= '0;
      rr_ptr_reg     <= '0;
      have_best_reg  <= 1'b0;
      best_id_reg    <= '0;
      best_wt_reg    <= 1'b0;
      best_fdsti_reg <= '0;
      best_fdssi_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_id_reg     <= '0;
      out_wt_reg     <= 1'b0;
      out_fdsti_reg  <= '0;
      out_fdssi_reg  <= '0;
      grant_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cand_reg       <= cand_next;
      cnt_reg        <= cnt_next;
      rr_ptr_reg     <= rr_ptr_next;
      have_best_reg  <= have_best_next;
      best_id_reg    <= best_id_next;
      best_wt_reg    <= best_wt_next;
      best_fdsti_reg <= best_fdsti_next;
      best_fdssi_reg <= best_fdssi_next;
      out_valid_reg  <= out_valid_next;
      out_id_reg     <= out_id_next;
      out_wt_reg     <= out_wt_next;
      out_fdsti_reg  <= out_fdsti_next;
      out_fdssi_reg  <= out_fdssi_next;
      grant_reg      <= grant_next;
    end
  end

  assign bus.req_grant = grant_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.out_wt    = out_wt_reg;
  assign bus.out_fdsti = out_fdsti_reg;
  assign bus.out_fdssi = out_fdssi_reg;
  assign bus.busy      = (state_reg != ST_IDLE);

  // A snapshotted requester must hold valid until the round that took it ends.
  for (genvar gi = 0; gi < N; gi++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (state_reg != ST_IDLE && cand_reg[gi]) |-> bus.req_valid[gi]);
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_reg));
endmodule

// File: tb/tb_fdsti_fdssi_seq_arb.sv
// Directed bench for fdsti_fdssi_seq_arb with N=4 and default widths.
module tb_fdsti_fdssi_seq_arb;
  localparam int SW = 2;
  localparam int TW = 28;
  localparam int FW = 12;
  localparam int N  = 1 << SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fdsti_fdssi_seq_arb_if #(.O_SAM_WIDTH(SW), .I_FDSTI_WIDTH(TW), .I_FDSSI_WIDTH(FW)) bus ();

  fdsti_fdssi_seq_arb #(.O_SAM_WIDTH(SW), .I_FDSTI_WIDTH(TW), .I_FDSSI_WIDTH(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wt, input logic [TW-1:0] t, input logic [FW-1:0] s);
    bus.req_valid[i]        = 1'b1;
    bus.req_wt[i]           = wt;
    bus.req_fdsti[i*TW +: TW] = t;
    bus.req_fdssi[i*FW +: FW] = s;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
  endtask

  // Accept the presented winner, check the grant pulse, drop requesters in clr_mask, then check that the grant clears.
  task automatic pop(input string tag, input int exp_id, input logic [N-1:0] clr_mask);
    logic [N-1:0] exp_grant;
    exp_grant = '0;
    exp_grant[exp_id] = 1'b1;
    check({tag, "_id"}, 64'(bus.out_id), 64'(exp_id));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_grant"}, 64'(bus.req_grant), 64'(exp_grant));
    check({tag, "_vld_drop"}, 64'(bus.out_valid), 64'd0);
    $display("txn %s id=%0d grant=%b", tag, exp_id, bus.req_grant);
    bus.req_valid = bus.req_valid & ~clr_mask;
    tick();
    check({tag, "_grant_clr"}, 64'(bus.req_grant), 64'd0);
  endtask

  initial begin
    bus.cfg_en    = 1'b1;
    bus.req_valid = '0;
    bus.req_wt    = '0;
    bus.req_fdsti = '0;
    bus.req_fdssi = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_grant", 64'(bus.req_grant), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_out_fdsti", 64'(bus.out_fdsti), 64'd0);
    rst_n = 1'b1;
    tick();

    // The request is sampled at edge k. out_valid must rise exactly after edge k+N+1.
    set_req(2, 1'b0, 28'd5, 12'h011);
    tick();
    check("t1_busy", 64'(bus.busy), 64'd1);
    for (int c = 1; c <= N; c++) begin
      tick();
      check($sformatf("t1_lat%0d", c), 64'(bus.out_valid), 64'd0);
    end
    tick();
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_fdsti", 64'(bus.out_fdsti), 64'd5);
    check("t1_fdssi", 64'(bus.out_fdssi), 64'h011);
    check("t1_wt", 64'(bus.out_wt), 64'd0);
    pop("t1", 2, 4'b0100);
    check("t1_idle", 64'(bus.busy), 64'd0);

    // FDSTI tie between 1 and 3 is broken by the smaller FDSSI.
    set_req(0, 1'b0, 28'd9, 12'd0);
    set_req(1, 1'b0, 28'd3, 12'd8);
    set_req(2, 1'b0, 28'd7, 12'd0);
    set_req(3, 1'b0, 28'd3, 12'd4);
    wait_out("t2");
    check("t2_fdssi", 64'(bus.out_fdssi), 64'd4);
    pop("t2", 3, 4'b1111);

    // Weight dominates FDSTI.
    set_req(0, 1'b0, 28'd1, 12'd0);
    set_req(1, 1'b1, 28'd100, 12'd0);
    wait_out("t3");
    check("t3_wt", 64'(bus.out_wt), 64'd1);
    check("t3_fdsti", 64'(bus.out_fdsti), 64'd100);
    pop("t3", 1, 4'b0011);

    // Reset returns rr_ptr to 0. Identical held requests must then rotate 0,1,2,3,0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 28'd50, 12'd7);
    for (int r = 0; r < 5; r++) begin
      wait_out($sformatf("t4_r%0d", r));
      pop($sformatf("t4_r%0d", r), r % N, (r == 4) ? 4'b1111 : 4'b0000);
    end

    // A stalled consumer holds the result steady and receives no grant.
    set_req(1, 1'b0, 28'h0ABCDEF, 12'h123);
    wait_out("t5");
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("t5_hold_vld%0d", c), 64'(bus.out_valid), 64'd1);
      check($sformatf("t5_hold_fdsti%0d", c), 64'(bus.out_fdsti), 64'h0ABCDEF);
      check($sformatf("t5_hold_grant%0d", c), 64'(bus.req_grant), 64'd0);
    end
    check("t5_fdssi", 64'(bus.out_fdssi), 64'h123);
    pop("t5", 1, 4'b0010);

    // Reset mid-SCAN drops the round without a grant.
    set_req(0, 1'b0, 28'd20, 12'd0);
    set_req(2, 1'b0, 28'd10, 12'd0);
    tick();
    tick();
    check("t6_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy_rst", 64'(bus.busy), 64'd0);
    check("t6_valid_rst", 64'(bus.out_valid), 64'd0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("t6_no_grant%0d", c), 64'(bus.req_grant), 64'd0);
    end
    check("t6_valid_post", 64'(bus.out_valid), 64'd0);

    // With cfg_en low, pending requests are ignored. Disabling after the snapshot does not abort the round.
    bus.cfg_en = 1'b0;
    set_req(0, 1'b1, 28'h200, 12'd1);
    set_req(3, 1'b1, 28'h200, 12'd0);
    for (int c = 0; c < 8; c++) tick();
    check("t7_idle_busy", 64'(bus.busy), 64'd0);
    check("t7_idle_valid", 64'(bus.out_valid), 64'd0);
    bus.cfg_en = 1'b1;
    tick();
    check("t7_busy", 64'(bus.busy), 64'd1);
    bus.cfg_en = 1'b0;
    wait_out("t7");
    pop("t7", 3, 4'b1001);
    bus.cfg_en = 1'b1;

    // A full tie goes to the first requester in scan order. Starting from rr_ptr 0 that is 1, then 3.
    set_req(1, 1'b0, 28'h40, 12'd2);
    set_req(3, 1'b0, 28'h40, 12'd2);
    wait_out("t8a");
    pop("t8a", 1, 4'b0000);
    wait_out("t8b");
    pop("t8b", 3, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
